// File: rtl/rgb48_unpack.sv
// -----------------------------------------------------------------------------
// rgb48_unpack
//
// Stream unpacker. It takes 48-bit two-pixel words over a valid/ready
// handshake and emits one 24-bit pixel per clock. It regenerates DE, HSYNC
// and VSYNC on the way out.
//
// A word carrying sof produces a VSYNC pulse of VS_WIDTH clocks before its
// first pixel. A word carrying eol produces an HSYNC pulse of HS_WIDTH clocks
// after its second pixel. The HSYNC pulse is followed by one idle clock.
// Words accepted while the second pixel is on the output are emitted
// gap-free, so DE stays continuous within a line.
//
// Handshake: a word transfers on a rising edge where I_48rgb_valid and
// O_48rgb_ready are both high. While valid is high and ready is low, upstream
// holds data, sof and eol stable. sof/eol are ignored when valid is low.
//
// Parameters
//   LOW_FIRST : 1 emits bits [23:0] first, 0 emits bits [47:24] first
//   HS_WIDTH  : HSYNC pulse length in clocks (>= 1)
//   VS_WIDTH  : VSYNC pulse length in clocks (>= 1)
//
// Ports
//   I_pixel_clk   : pixel clock, rising edge
//   rst_n         : asynchronous active-low reset
//   I_pixel_data  : 48-bit two-pixel word
//   I_48rgb_valid : word valid
//   I_48rgb_sof   : word is first of frame (qualified by valid)
//   I_48rgb_eol   : word is last of line (qualified by valid)
//   O_48rgb_ready : word accepted on an edge where valid & ready
//   O_pixel_data  : output pixel, zero whenever DE is low
//   O_24rgb_de    : pixel valid
//   O_24rgb_hsync : active-high line sync
//   O_24rgb_vsync : active-high frame sync
//   O_fsm_state   : current FSM state (observability only)
// -----------------------------------------------------------------------------
module rgb48_unpack #(
    parameter int LOW_FIRST = 1,
    parameter int HS_WIDTH  = 4,
    parameter int VS_WIDTH  = 8
) (
    input  logic        I_pixel_clk,
    input  logic        rst_n,
    input  logic [47:0] I_pixel_data,
    input  logic        I_48rgb_valid,
    input  logic        I_48rgb_sof,
    input  logic        I_48rgb_eol,
    output logic        O_48rgb_ready,
    output logic [23:0] O_pixel_data,
    output logic        O_24rgb_de,
    output logic        O_24rgb_hsync,
    output logic        O_24rgb_vsync,
    output logic [2:0]  O_fsm_state
);

    localparam int MAX_W = (HS_WIDTH > VS_WIDTH) ? HS_WIDTH : VS_WIDTH;
    localparam int CW    = $clog2(MAX_W + 1);

    localparam logic [CW-1:0] HS_LOAD = CW'(HS_WIDTH - 1);
    localparam logic [CW-1:0] VS_LOAD = CW'(VS_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_VS   = 3'd1,
        S_LO   = 3'd2,
        S_HI   = 3'd3,
        S_HS   = 3'd4
    } state_t;

    state_t        state_q;
    logic [47:0]   w_data_q;
    logic          w_sof_q;
    logic          w_eol_q;
    logic          full_q;
    logic [CW-1:0] cnt_q;

    logic          accept;

    function automatic logic [23:0] first_half(input logic [47:0] d);
        return (LOW_FIRST != 0) ? d[23:0] : d[47:24];
    endfunction

    function automatic logic [23:0] second_half(input logic [47:0] d);
        return (LOW_FIRST != 0) ? d[47:24] : d[23:0];
    endfunction

    // The holding register may refill on the same edge its second pixel
    // leaves. That is what keeps back-to-back words gap-free.
    assign O_48rgb_ready = !full_q || (state_q == S_HI);
    assign accept        = I_48rgb_valid && O_48rgb_ready;
    assign O_fsm_state   = state_q;

    always_ff @(posedge I_pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            w_data_q      <= '0;
            w_sof_q       <= 1'b0;
            w_eol_q       <= 1'b0;
            full_q        <= 1'b0;
            cnt_q         <= '0;
            O_pixel_data  <= '0;
            O_24rgb_de    <= 1'b0;
            O_24rgb_hsync <= 1'b0;
            O_24rgb_vsync <= 1'b0;
        end else begin
            if (accept) begin
                w_data_q <= I_pixel_data;
                w_sof_q  <= I_48rgb_sof;
                w_eol_q  <= I_48rgb_eol;
                full_q   <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    // ready is low here whenever full_q is set, so W is stable.
                    if (full_q) begin
                        if (w_sof_q) begin
                            state_q       <= S_VS;
                            cnt_q         <= VS_LOAD;
                            O_24rgb_vsync <= 1'b1;
                        end else begin
                            state_q      <= S_LO;
                            O_24rgb_de   <= 1'b1;
                            O_pixel_data <= first_half(w_data_q);
                        end
                    end
                end

                S_VS: begin
                    if (cnt_q == '0) begin
                        state_q       <= S_LO;
                        O_24rgb_vsync <= 1'b0;
                        O_24rgb_de    <= 1'b1;
                        O_pixel_data  <= first_half(w_data_q);
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                S_LO: begin
                    state_q      <= S_HI;
                    O_pixel_data <= second_half(w_data_q);
                end

                S_HI: begin
                    if (!accept) begin
                        full_q <= 1'b0;
                    end
                    if (w_eol_q) begin
                        // Any word taken on this edge waits in W until after the
                        // HSYNC pulse and the idle clock that follows it.
                        state_q       <= S_HS;
                        cnt_q         <= HS_LOAD;
                        O_24rgb_de    <= 1'b0;
                        O_pixel_data  <= '0;
                        O_24rgb_hsync <= 1'b1;
                    end else if (accept) begin
                        if (I_48rgb_sof) begin
                            state_q       <= S_VS;
                            cnt_q         <= VS_LOAD;
                            O_24rgb_de    <= 1'b0;
                            O_pixel_data  <= '0;
                            O_24rgb_vsync <= 1'b1;
                        end else begin
                            // W is only being loaded on this edge, so the first
                            // pixel comes straight from the input bus.
                            state_q      <= S_LO;
                            O_pixel_data <= first_half(I_pixel_data);
                        end
                    end else begin
                        state_q      <= S_IDLE;
                        O_24rgb_de   <= 1'b0;
                        O_pixel_data <= '0;
                    end
                end

                S_HS: begin
                    if (cnt_q == '0) begin
                        state_q       <= S_IDLE;
                        O_24rgb_hsync <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                default: begin
                    state_q       <= S_IDLE;
                    O_24rgb_de    <= 1'b0;
                    O_24rgb_hsync <= 1'b0;
                    O_24rgb_vsync <= 1'b0;
                    O_pixel_data  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgb48_unpack.sv
module tb_rgb48_unpack;

  localparam int HS = 4;
  localparam int VS = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [47:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic        in_eol = 1'b0;

  logic        rdy_a, de_a, hs_a, vs_a;
  logic [23:0] pix_a;
  logic [2:0]  st_a;
  logic        rdy_b, de_b, hs_b, vs_b;
  logic [23:0] pix_b;
  logic [2:0]  st_b;

  // Low half emitted first.
  rgb48_unpack #(.LOW_FIRST(1), .HS_WIDTH(HS), .VS_WIDTH(VS)) dut (
    .I_pixel_clk(clk), .rst_n(rst_n), .I_pixel_data(in_data),
    .I_48rgb_valid(in_valid), .I_48rgb_sof(in_sof), .I_48rgb_eol(in_eol),
    .O_48rgb_ready(rdy_a), .O_pixel_data(pix_a), .O_24rgb_de(de_a),
    .O_24rgb_hsync(hs_a), .O_24rgb_vsync(vs_a), .O_fsm_state(st_a)
  );

  // High half emitted first, same stimulus.
  rgb48_unpack #(.LOW_FIRST(0), .HS_WIDTH(HS), .VS_WIDTH(VS)) dut_hf (
    .I_pixel_clk(clk), .rst_n(rst_n), .I_pixel_data(in_data),
    .I_48rgb_valid(in_valid), .I_48rgb_sof(in_sof), .I_48rgb_eol(in_eol),
    .O_48rgb_ready(rdy_b), .O_pixel_data(pix_b), .O_24rgb_de(de_b),
    .O_24rgb_hsync(hs_b), .O_24rgb_vsync(vs_b), .O_fsm_state(st_b)
  );

  // ---------------- reference model ----------------
  // Output timeline: edge number -> expected beat. Missing entries are idle.
  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] d_lf;
    logic [23:0] d_hf;
  } beat_t;

  beat_t sched[int];
  int    cyc;
  int    h_last;     // edge on which the latest word shows its second pixel
  int    last_beat;  // edge of the latest scheduled beat
  logic  last_eol;

  int checks = 0;
  int errors = 0;

  function automatic void model_clear();
    sched.delete();
    h_last    = -100;
    last_beat = -100;
    last_eol  = 1'b0;
  endfunction

  // The register is free once the previous word is showing its last pixel.
  function automatic logic model_ready();
    return (h_last <= cyc);
  endfunction

  function automatic void model_accept(input int k, input logic [47:0] d,
                                       input logic sof, input logic eol);
    int    start;
    int    t;
    beat_t b;
    if (!last_eol && k == last_beat + 1)
      start = k;                                 // gap-free continuation
    else begin
      start = k + 1;
      if (last_beat + (last_eol ? 2 : 1) > start)
        start = last_beat + (last_eol ? 2 : 1);  // sync pulse + idle clock first
    end
    t = start;
    if (sof) begin
      for (int i = 0; i < VS; i++) begin
        b = '0; b.vs = 1'b1; sched[t] = b; t++;
      end
    end
    b = '0; b.de = 1'b1; b.d_lf = d[23:0];  b.d_hf = d[47:24]; sched[t] = b; t++;
    h_last = t;
    b = '0; b.de = 1'b1; b.d_lf = d[47:24]; b.d_hf = d[23:0];  sched[t] = b; t++;
    if (eol) begin
      for (int i = 0; i < HS; i++) begin
        b = '0; b.hs = 1'b1; sched[t] = b; t++;
      end
    end
    last_beat = t - 1;
    last_eol  = eol;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d: observed %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    beat_t e;
    e = sched.exists(cyc) ? sched[cyc] : '0;
    check("de_a",  {31'd0, de_a}, {31'd0, e.de});
    check("hs_a",  {31'd0, hs_a}, {31'd0, e.hs});
    check("vs_a",  {31'd0, vs_a}, {31'd0, e.vs});
    check("pix_a", {8'd0, pix_a}, {8'd0, e.d_lf});
    check("de_b",  {31'd0, de_b}, {31'd0, e.de});
    check("pix_b", {8'd0, pix_b}, {8'd0, e.d_hf});
    if (sched.exists(cyc - 4)) sched.delete(cyc - 4);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pix"},   {8'd0, pix_a}, 32'd0);
    check({tag, "_de"},    {31'd0, de_a}, 32'd0);
    check({tag, "_hs"},    {31'd0, hs_a}, 32'd0);
    check({tag, "_vs"},    {31'd0, vs_a}, 32'd0);
    check({tag, "_ready"}, {31'd0, rdy_a}, 32'd1);
    check({tag, "_pix_b"}, {8'd0, pix_b}, 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  // One clock: check ready, advance an edge, update model, check outputs.
  logic last_acc;
  task automatic tick();
    logic exp_rdy;
    exp_rdy = model_ready();
    check("ready_a", {31'd0, rdy_a}, {31'd0, exp_rdy});
    check("ready_b", {31'd0, rdy_b}, {31'd0, exp_rdy});
    last_acc = in_valid && exp_rdy;
    @(posedge clk);
    cyc++;
    if (last_acc) model_accept(cyc, in_data, in_sof, in_eol);
    #1;
    check_outputs();
  endtask

  // Present a word and hold it stable until it transfers. valid stays high.
  task automatic send_word(input logic [47:0] d, input logic sof, input logic eol);
    int n;
    in_valid = 1'b1; in_data = d; in_sof = sof; in_eol = eol;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 64);
    if (!last_acc) begin
      errors++;
      $display("FAIL send_word timeout: word %0h not accepted in 64 cycles", d);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof   = $urandom_range(0, 1);
    in_eol   = $urandom_range(0, 1);
    in_data  = {$urandom, $urandom};
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic reset_pulse();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); cyc++; #1;
      check_reset_outputs("rst_hold");
    end
    rst_n = 1'b1;
    model_clear();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cyc = 0;
    model_clear();

    // Reset held with a valid word on the bus: nothing may be taken.
    in_valid = 1'b1; in_data = 48'h111111_222222; in_sof = 1'b0; in_eol = 1'b0;
    #1;
    check_reset_outputs("rst");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_reset_outputs("rst");
    end
    rst_n = 1'b1;

    // Single word, already on the bus, taken on the first edge after release.
    send_word(48'h111111_222222, 1'b0, 1'b0);
    tick();
    check("single_first_lf", {8'd0, pix_a}, 32'h222222);
    check("single_first_hf", {8'd0, pix_b}, 32'h111111);
    in_valid = 1'b0;
    tick();
    check("single_second_lf", {8'd0, pix_a}, 32'h111111);
    idle(4);

    // Four back-to-back words, eol on the last one.
    send_word(48'h0A0A0A_010101, 1'b0, 1'b0);
    send_word(48'h0B0B0B_020202, 1'b0, 1'b0);
    send_word(48'h0C0C0C_030303, 1'b0, 1'b0);
    send_word(48'h0D0D0D_040404, 1'b0, 1'b1);
    idle(10);

    // Start-of-frame word.
    send_word(48'hAAAAAA_BBBBBB, 1'b1, 1'b0);
    idle(12);

    // sof and eol on the same word.
    send_word(48'h123456_789ABC, 1'b1, 1'b1);
    idle(16);

    // Backpressure: next word arrives during HSYNC, a third one waits.
    send_word(48'h555555_666666, 1'b0, 1'b1);
    idle(3);
    send_word(48'h777777_888888, 1'b0, 1'b0);
    send_word(48'h999999_CCCCCC, 1'b0, 1'b0);
    idle(6);

    // Reset in the middle of a word's first pixel.
    send_word(48'hDEAD00_BEEF00, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();
    check("pre_reset_de", {31'd0, de_a}, 32'd1);
    reset_pulse();
    idle(3);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0)
        idle($urandom_range(1, 3));
      else
        send_word({$urandom, $urandom}, ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0));
    end
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
